// File: rtl/dfm_pkg.sv
// dfm_pkg: shared opcodes, sequencer states and default cycle budgets for the frequency meter
package dfm_pkg;
  typedef enum logic [1:0] {
    OP_FREQ     = 2'b00,
    OP_PERIOD   = 2'b01,
    OP_INTERVAL = 2'b10,
    OP_STOP     = 2'b11
  } opcode_t;
  typedef enum logic [2:0] {
    IDLE, MSTART, MACK, MWAIT, CSTART, CACK, CWAIT, HOLD
  } seq_state_t;
  localparam int DEF_ACK_WAIT = 4;
  localparam int DEF_TIMEOUT  = 100_000_000;
  localparam int DEF_HOLDOFF  = 5_000_000;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/engine_handshake.sv
// engine_handshake: start pulse plus ack/busy watchdog for one engine, timed by the shared counter
module engine_handshake
  import dfm_pkg::*;
#(
  parameter int ACK_WAIT = DEF_ACK_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CW       = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fire,
  input  logic          acking,
  input  logic          waiting,
  input  logic          busy,
  input  logic          tc,
  output logic          start,
  output logic          hs_ack,
  output logic          hs_done,
  output logic          hs_err,
  output logic [CW-1:0] load
);
  always_ff @(posedge clk) start <= rst ? 1'b0 : fire;
  assign hs_ack  = acking && busy;
  assign hs_done = waiting && !busy;
  // a busy edge on the terminal count wins over the timeout
  assign hs_err  = tc && (acking ? !busy : waiting && busy);
  assign load    = fire ? CW'(ACK_WAIT - 1) : CW'(TIMEOUT - 1);
endmodule

// File: rtl/measure_sequencer.sv
// measure_sequencer: runs measure engine then serial unit per command, with auto-repeat and watchdogs
module measure_sequencer
  import dfm_pkg::*;
#(
  parameter int ACK_WAIT       = DEF_ACK_WAIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] opcode,
  input  logic       cont,
  output logic       ready,
  input  logic       Fbusy,
  input  logic       Tbusy,
  input  logic       Cbusy,
  output logic       Fstart,
  output logic       Tstart,
  output logic       Cstart,
  output logic [1:0] mode,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2(max3(ACK_WAIT, TIMEOUT_CYCLES, HOLDOFF_CYCLES));
  seq_state_t state, nxt;
  logic [CW-1:0] cnt, reload, m_load, c_load;
  logic cont_q, tc, stop, accept, mbusy;
  logic m_start, m_ack, m_done, m_err, c_start, c_ack, c_done, c_err;
  assign tc     = cnt == '0;
  assign stop   = cmd_valid && opcode == OP_STOP;
  assign accept = cmd_valid && ready && opcode != OP_STOP;
  assign mbusy  = mode == OP_FREQ ? Fbusy : Tbusy;
  // mode only changes on accept, when no start pulse is in flight
  assign Fstart = m_start && mode == OP_FREQ;
  assign Tstart = m_start && mode != OP_FREQ;
  assign Cstart = c_start;
  engine_handshake #(.ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT_CYCLES), .CW(CW)) u_meas (
    .clk(clk), .rst(rst), .fire(state == MSTART), .acking(state == MACK),
    .waiting(state == MWAIT), .busy(mbusy), .tc(tc), .start(m_start),
    .hs_ack(m_ack), .hs_done(m_done), .hs_err(m_err), .load(m_load)
  );
  engine_handshake #(.ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT_CYCLES), .CW(CW)) u_ser (
    .clk(clk), .rst(rst), .fire(state == CSTART), .acking(state == CACK),
    .waiting(state == CWAIT), .busy(Cbusy), .tc(tc), .start(c_start),
    .hs_ack(c_ack), .hs_done(c_done), .hs_err(c_err), .load(c_load)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? MSTART : IDLE;
      MSTART:  nxt = MACK;
      MACK:    nxt = m_err ? IDLE : m_ack ? MWAIT : MACK;
      MWAIT:   nxt = m_err ? IDLE : m_done ? CSTART : MWAIT;
      CSTART:  nxt = CACK;
      CACK:    nxt = c_err ? IDLE : c_ack ? CWAIT : CACK;
      CWAIT:   nxt = c_err ? IDLE : c_done ? (cont_q && !stop ? HOLD : IDLE) : CWAIT;
      HOLD:    nxt = stop ? IDLE : tc ? MSTART : HOLD;
      default: nxt = IDLE;
    endcase
  end
  assign reload = nxt == HOLD ? CW'(HOLDOFF_CYCLES - 1) : (nxt == MACK || nxt == MWAIT) ? m_load : c_load;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode   <= OP_FREQ;
      cont_q <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      state  <= nxt;
      cnt    <= nxt != state ? reload : tc ? cnt : cnt - CW'(1);
      mode   <= accept ? opcode : mode;
      cont_q <= accept ? cont : stop ? 1'b0 : cont_q;
      err    <= accept ? 1'b0 : (m_err || c_err) ? 1'b1 : err;
      done   <= c_done;
      ready  <= nxt == IDLE && state != CWAIT;
    end
  end
endmodule

// File: tb/tb_measure_sequencer.sv
// tb_measure_sequencer: directed bench with a done/mode scoreboard; dut_t carries a short busy timeout
module tb_measure_sequencer;
  import dfm_pkg::*;
  logic clk = 0, rst = 1, cmd_valid = 0, cont = 0, Fbusy = 0, Tbusy = 0, Cbusy = 0;
  logic [1:0] opcode = 2'b00;
  logic ready, Fstart, Tstart, Cstart, done, err;
  logic [1:0] mode;
  logic ready_t, Fstart_t, Tstart_t, Cstart_t, done_t, err_t;
  logic [1:0] mode_t;
  int n_cmp = 0, n_bad = 0, cyc = 0, nf = 0, nt = 0, nc = 0, nd = 0, nd_t = 0;
  logic [1:0] exp_q[$];
  always #5 clk = ~clk;
  measure_sequencer #(.ACK_WAIT(4), .TIMEOUT_CYCLES(200), .HOLDOFF_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .opcode(opcode), .cont(cont), .ready(ready),
    .Fbusy(Fbusy), .Tbusy(Tbusy), .Cbusy(Cbusy), .Fstart(Fstart), .Tstart(Tstart),
    .Cstart(Cstart), .mode(mode), .done(done), .err(err)
  );
  measure_sequencer #(.ACK_WAIT(4), .TIMEOUT_CYCLES(20), .HOLDOFF_CYCLES(10)) dut_t (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .opcode(opcode), .cont(cont), .ready(ready_t),
    .Fbusy(Fbusy), .Tbusy(Tbusy), .Cbusy(Cbusy), .Fstart(Fstart_t), .Tstart(Tstart_t),
    .Cstart(Cstart_t), .mode(mode_t), .done(done_t), .err(err_t)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // one cycle: sample just after the falling edge, count pulses, retire scoreboard entries on done
  task automatic step();
    logic [1:0] m;
    @(negedge clk);
    #1;
    cyc++;
    if (Fstart) nf++;
    if (Tstart) nt++;
    if (Cstart) nc++;
    if (done_t) nd_t++;
    if (done) begin
      nd++;
      chk("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        m = exp_q.pop_front();
        chk("sb_mode", mode, m);
      end
    end
  endtask
  task automatic set_busy(input int sel, input logic v);
    if (sel == 0) Fbusy = v;
    else if (sel == 1) Tbusy = v;
    else Cbusy = v;
  endtask
  task automatic wait_start(input int sel);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = sel == 0 ? Fstart : sel == 1 ? Tstart : Cstart;
    end
    chk("start_seen", seen, 1);
  endtask
  task automatic drive(input int sel, input int d, input int len);
    repeat (d) step();
    set_busy(sel, 1'b1);
    repeat (len) step();
    set_busy(sel, 1'b0);
  endtask
  task automatic issue(input logic [1:0] op, input logic c);
    for (int i = 0; i < 40 && !ready; i++) step();
    chk("issue_ready", ready, 1);
    opcode = op;
    cont = c;
    cmd_valid = 1;
    step();
    cmd_valid = 0;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && !done; i++) step();
    chk(tag, done, 1);
  endtask
  initial begin
    int t[3];
    int k;
    repeat (3) step();
    chk("rst_outs", {ready, mode, Fstart, Tstart, Cstart, done, err}, 8'b1000_0000);
    chk("rst_t_outs", {ready_t, mode_t, Fstart_t, Tstart_t, Cstart_t, done_t, err_t}, 8'b1000_0000);
    rst = 0;
    step();
    // single-shot frequency
    exp_q.push_back(OP_FREQ);
    issue(OP_FREQ, 0);
    chk("acc_ready_fall", ready, 0);
    chk("acc_no_start_yet", Fstart, 0);
    step();
    chk("acc_to_fstart", Fstart, 1);
    drive(0, 2, 100);
    repeat (2) step();
    chk("fall_to_cstart", Cstart, 1);
    drive(2, 2, 50);
    step();
    chk("cfall_to_done", done, 1);
    chk("ready_low_at_done", ready, 0);
    step();
    chk("done_to_ready", ready, 1);
    chk("ss_counts", {nf[7:0], nt[7:0], nc[7:0], nd[7:0]}, {8'd1, 8'd0, 8'd1, 8'd1});
    chk("ss_mode", mode, OP_FREQ);
    // continuous interval: period = (4+12) + (4+6) + 10 holdoff
    nf = 0; nt = 0; nc = 0; nd = 0;
    repeat (3) exp_q.push_back(OP_INTERVAL);
    issue(OP_INTERVAL, 1);
    for (int r = 0; r < 3; r++) begin
      wait_start(1);
      t[r] = cyc;
      drive(1, 2, 12);
      wait_start(2);
      drive(2, 2, 6);
    end
    step();
    chk("cont_done3", nd, 3);
    chk("cont_period1", t[1] - t[0], 36);
    chk("cont_period2", t[2] - t[1], 36);
    opcode = OP_STOP;
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    chk("stop_hold_idle", ready, 1);
    repeat (50) step();
    chk("stop_no_more", nt, 3);
    chk("cont_mode", mode, OP_INTERVAL);
    // stop in the same cycle as the transmit completes
    nf = 0; nd = 0;
    exp_q.push_back(OP_FREQ);
    issue(OP_FREQ, 1);
    wait_start(0);
    drive(0, 2, 5);
    wait_start(2);
    repeat (2) step();
    Cbusy = 1;
    repeat (5) step();
    Cbusy = 0;
    opcode = OP_STOP;
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    chk("stop_done_pulse", done, 1);
    repeat (20) step();
    chk("stop_done_idle", {nf[7:0], nd[7:0]}, 16'h0101);
    chk("stop_done_ready", ready, 1);
    // ack timeout on the period engine
    nc = 0;
    issue(OP_PERIOD, 0);
    step();
    chk("ack_tstart", Tstart, 1);
    k = 0;
    while (k < 6 && !err) begin
      step();
      k++;
    end
    chk("ack_err", err, 1);
    chk("ack_err_lat", k, 4);
    chk("ack_idle", ready, 1);
    repeat (10) step();
    chk("ack_no_cstart", nc, 0);
    exp_q.push_back(OP_FREQ);
    issue(OP_FREQ, 0);
    chk("err_cleared", err, 0);
    wait_start(0);
    drive(0, 2, 3);
    wait_start(2);
    drive(2, 2, 3);
    wait_done("ack_recover_done");
    // busy timeout boundary on the short-timeout instance
    rst = 1;
    repeat (2) step();
    rst = 0;
    nd_t = 0;
    exp_q.push_back(OP_FREQ);
    issue(OP_FREQ, 0);
    wait_start(0);
    drive(0, 2, 20);
    step();
    chk("to20_no_err", err_t, 0);
    wait_start(2);
    drive(2, 2, 3);
    wait_done("to20_done");
    chk("to20_done_t", nd_t, 1);
    exp_q.push_back(OP_FREQ);
    issue(OP_FREQ, 0);
    wait_start(0);
    drive(0, 2, 21);
    chk("to21_err", err_t, 1);
    chk("to21_ready_t", ready_t, 1);
    chk("to21_main_ok", err, 0);
    wait_start(2);
    drive(2, 2, 3);
    wait_done("to21_main_done");
    chk("to21_no_done_t", nd_t, 1);
    // reset while waiting on the serial unit
    nd = 0;
    issue(OP_PERIOD, 0);
    wait_start(1);
    drive(1, 2, 4);
    wait_start(2);
    repeat (2) step();
    Cbusy = 1;
    repeat (3) step();
    rst = 1;
    step();
    chk("mrst_outs", {ready, mode, Fstart, Tstart, Cstart, done, err}, 8'b1000_0000);
    chk("mrst_t_outs", {ready_t, mode_t, Fstart_t, Tstart_t, Cstart_t, done_t, err_t}, 8'b1000_0000);
    Cbusy = 0;
    rst = 0;
    repeat (10) step();
    chk("mrst_no_done", nd, 0);
    // non-stop command while busy is held off until ready
    exp_q.push_back(OP_FREQ);
    issue(OP_FREQ, 0);
    wait_start(0);
    repeat (2) step();
    Fbusy = 1;
    repeat (2) step();
    opcode = OP_PERIOD;
    cmd_valid = 1;
    repeat (3) step();
    chk("ign_mode", mode, OP_FREQ);
    chk("ign_ready", ready, 0);
    Fbusy = 0;
    exp_q.push_back(OP_PERIOD);
    wait_start(2);
    drive(2, 2, 3);
    wait_done("ign_first_done");
    k = 0;
    while (k < 5 && mode != OP_PERIOD) begin
      step();
      k++;
    end
    chk("ign_accept_lat", k, 2);
    chk("ign_ready_fall", ready, 0);
    cmd_valid = 0;
    wait_start(1);
    drive(1, 2, 3);
    wait_start(2);
    drive(2, 2, 3);
    wait_done("ign_second_done");
    step();
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
